// File: rtl/counting_gen.sv
// Pattern transmitter: replays a latched sequence of 2-bit symbols a set number
// of times, with optional hold gaps between repetitions. All outputs are registered.
module counting_gen #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*MAX_LEN-1:0] pattern,
    input  logic [3:0]           len,
    input  logic [CNT_W-1:0]     rpt,
    input  logic [GAP_W-1:0]     gap,
    input  logic                 abort,
    output logic [1:0]           num,
    output logic                 num_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_e;

    state_e               state_q, state_d;
    logic [2*MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]           len_q, len_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [CNT_W-1:0]     rep_q, rep_d;
    logic [GAP_W-1:0]     gcnt_q, gcnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [1:0]           num_q, num_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    function automatic logic [1:0] sym_at(input logic [2*MAX_LEN-1:0] p, input logic [3:0] i);
        logic [2*MAX_LEN-1:0] s;
        s = p >> {i, 1'b0};
        return s[1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        gcnt_d  = gcnt_q;
        idx_d   = idx_q;
        num_d   = 2'd0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    if (len == 4'd0 || 32'(len) > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d  = pattern;
                        len_d  = len;
                        gap_d  = gap;
                        rep_d  = rpt;
                        idx_d  = 4'd0;
                        busy_d = 1'b1;
                        if (rpt == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = EMIT;
                            vld_d   = 1'b1;
                        end
                    end
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    // rep_q counts repetitions still owed, including the current one
                    if (idx_q == len_q - 4'd1) begin
                        if (rep_q == CNT_W'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            rep_d = rep_q - CNT_W'(1);
                            idx_d = 4'd0;
                            if (gap_q != '0) begin
                                state_d = GAP;
                                gcnt_d  = gap_q;
                            end else begin
                                vld_d = 1'b1;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        vld_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (gcnt_q == GAP_W'(1)) begin
                        state_d = EMIT;
                        vld_d   = 1'b1;
                    end else begin
                        gcnt_d = gcnt_q - GAP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (vld_d) num_d = sym_at(pat_d, idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            gcnt_q  <= gcnt_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign num       = num_q;
    assign num_valid = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counting_gen.sv
// Bench for counting_gen: table of run configurations expanded into a per-cycle
// expected trace (scoreboard queue), plus abort / reset / held-start sequences.
module tb_counting_gen;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int GAP_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [2*MAX_LEN-1:0] pattern = '0;
    logic [3:0]           len = '0;
    logic [CNT_W-1:0]     rpt = '0;
    logic [GAP_W-1:0]     gap = '0;
    logic [1:0]           num;
    logic                 num_valid, busy, done, err;

    counting_gen #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
        .rpt(rpt), .gap(gap), .abort(abort), .num(num), .num_valid(num_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] num;
        logic       vld;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct {
        logic [15:0] pat;
        logic [3:0]  len;
        logic [3:0]  rpt;
        logic [3:0]  gap;
        int          exp_busy;
    } vec_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t cur();
        obs_t o;
        o.num  = num;
        o.vld  = num_valid;
        o.busy = busy;
        o.done = done;
        o.err  = err;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got num=%0d vld=%0b busy=%0b done=%0b err=%0b, expected num=%0d vld=%0b busy=%0b done=%0b err=%0b",
                     name, got.num, got.vld, got.busy, got.done, got.err,
                     exp.num, exp.vld, exp.busy, exp.done, exp.err);
        end
    endtask

    task automatic push(input logic [1:0] n, input logic v, input logic b, input logic d, input logic e);
        obs_t o;
        o.num = n; o.vld = v; o.busy = b; o.done = d; o.err = e;
        sb.push_back(o);
    endtask

    // Expected cycle-by-cycle outputs following the accepting edge, plus one idle cycle.
    task automatic push_trace(input vec_t v);
        if (v.len == 4'd0 || int'(v.len) > MAX_LEN) begin
            push(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            for (int r = 0; r < int'(v.rpt); r++) begin
                for (int i = 0; i < int'(v.len); i++) push(v.pat[2*i +: 2], 1'b1, 1'b1, 1'b0, 1'b0);
                if (r < int'(v.rpt) - 1)
                    for (int g = 0; g < int'(v.gap); g++) push(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            push(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        push(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name, output int nbusy);
        obs_t o;
        nbusy = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            o = cur();
            if (o.busy) nbusy++;
            check(name, o, sb.pop_front());
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int nb;
        pattern = v.pat; len = v.len; rpt = v.rpt; gap = v.gap;
        start = 1'b1;
        push_trace(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        // scramble inputs: the run must use the latched config
        pattern = ~v.pat; len = 4'd2; rpt = 4'd0; gap = 4'd7;
        drain(name, nb);
        checks++;
        if (nb != v.exp_busy) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, nb, v.exp_busy);
        end
    endtask

    vec_t tbl[8];
    obs_t zero;

    initial begin
        int nb;
        int k;
        zero = '0;
        tbl[0] = '{16'h0039, 4'd3, 4'd1, 4'd0, 4};
        tbl[1] = '{16'h0039, 4'd3, 4'd2, 4'd2, 9};
        tbl[2] = '{16'h0039, 4'd0, 4'd2, 4'd0, 0};
        tbl[3] = '{16'h0039, 4'd9, 4'd2, 4'd0, 0};
        tbl[4] = '{16'h0039, 4'd3, 4'd0, 4'd1, 1};
        tbl[5] = '{16'hE4B1, 4'd8, 4'd3, 4'd1, 27};
        tbl[6] = '{16'h0002, 4'd1, 4'd4, 4'd3, 14};
        tbl[7] = '{16'h02D7, 4'd5, 4'd2, 4'd0, 11};

        @(negedge clk);
        check("reset_state", cur(), zero);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // abort during 2nd symbol of repetition 2
        pattern = 16'h0039; len = 4'd3; rpt = 4'd3; gap = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push(2'd1, 1, 1, 0, 0); push(2'd2, 1, 1, 0, 0); push(2'd3, 1, 1, 0, 0);
        push(2'd1, 1, 1, 0, 0); push(2'd2, 1, 1, 0, 0);
        drain("abort_pre", nb);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int i = 0; i < 4; i++) push(2'd0, 0, 0, 0, 0);
        drain("abort_post", nb);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) push(2'd0, 0, 0, 0, 0);
        drain("abort_start_idle", nb);

        run_vec(tbl[0], "after_abort");

        // asynchronous reset between edges mid-EMIT
        pattern = 16'h0039; len = 4'd3; rpt = 4'd2; gap = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        push(2'd1, 1, 1, 0, 0); push(2'd2, 1, 1, 0, 0);
        drain("pre_reset", nb);
        #2 rst_n = 1'b0;
        #1 check("reset_async", cur(), zero);
        @(negedge clk);
        check("reset_held", cur(), zero);
        rst_n = 1'b1;

        // start held high across a run: re-accepted only once back in IDLE
        pattern = tbl[0].pat; len = tbl[0].len; rpt = tbl[0].rpt; gap = tbl[0].gap;
        start = 1'b1;
        push_trace(tbl[0]);
        push_trace(tbl[0]);
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            check("held_start", cur(), sb.pop_front());
            k++;
            if (k == 6) start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
